i2s_audio_out: RTL and testbench

Audio output stage downstream of the radio core. It accepts 16-bit signed demodulated audio samples, one per sample_valid strobe, and buffers one sample. It serialises the sample as standard I2S (Philips format, 32-bit slots, MSB one bclk after lrclk edge) to an external audio DAC. Mono source: the same sample is sent in the left and right slots. Bit and word clocks are derived from the single system clock; underrun and overrun events are counted for debug.

---
 rtl/i2s_audio_out_if.sv | 26 ++
 rtl/i2s_audio_out.sv | 105 ++++++++++
 tb/tb_i2s_audio_out.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_audio_out_if.sv
// rtl/i2s_audio_out_if.sv - sample input and I2S output bundle for i2s_audio_out
interface i2s_audio_out_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] sample;
   logic             sample_valid;
   logic             bclk;
   logic             lrclk;
   logic             sdata;

   modport master (
      output sample,
      output sample_valid,
      input  bclk,
      input  lrclk,
      input  sdata
   );

   modport slave (
      input  sample,
      input  sample_valid,
      output bclk,
      output lrclk,
      output sdata
   );
endinterface

// File: rtl/i2s_audio_out.sv
// rtl/i2s_audio_out.sv - mono 16-bit sample buffer and Philips I2S serialiser (32-bit slots)
module i2s_audio_out #(
   parameter int DIV   = 4,
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           reset,
   i2s_audio_out_if.slave aud,
   input  logic           enable,
   output logic [7:0]     underruns,
   output logic [7:0]     overruns
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = $clog2(WIDTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [DW-1:0]    div_cnt;
   logic [5:0]       bit_cnt;
   logic [5:0]       bit_nxt;
   logic [4:0]       slot_pos;
   logic [4:0]       bit_idx;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] current;
   logic             pending_full;
   logic             bclk_q;
   logic             lrclk_q;
   logic             sdata_q;
   logic             sdata_nxt;
   logic             half_done;
   logic             fall;
   logic             frame_start;

   assign aud.bclk  = bclk_q;
   assign aud.lrclk = lrclk_q;
   assign aud.sdata = sdata_q;

   // Everything that changes on a bclk fall is computed from the post-increment bit position.
   always_comb begin
      half_done   = enable && (div_cnt == DIV_LAST);
      fall        = half_done && bclk_q;
      bit_nxt     = bit_cnt + 6'd1;
      frame_start = fall && (bit_nxt == 6'd0);
      slot_pos    = bit_nxt[4:0];
      bit_idx     = 5'(WIDTH) - slot_pos;
      sdata_nxt   = 1'b0;
      if ((slot_pos != 5'd0) && (slot_pos <= 5'(WIDTH))) begin
         sdata_nxt = current[bit_idx[IW-1:0]];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bit_cnt <= 6'd0;
         bclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
         sdata_q <= 1'b0;
      end else if (!enable) begin
         div_cnt <= '0;
         bit_cnt <= 6'd0;
         bclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
         sdata_q <= 1'b0;
      end else if (half_done) begin
         div_cnt <= '0;
         bclk_q  <= ~bclk_q;
         if (bclk_q) begin
            bit_cnt <= bit_nxt;
            lrclk_q <= bit_nxt[5];
            sdata_q <= sdata_nxt;
         end
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // A strobe on the frame-start edge lands after the consume, so it never counts as an overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending      <= '0;
         pending_full <= 1'b0;
         current      <= '0;
         underruns    <= 8'd0;
         overruns     <= 8'd0;
      end else begin
         if (frame_start) begin
            if (pending_full) begin
               current <= pending;
            end else if (underruns != 8'hFF) begin
               underruns <= underruns + 8'd1;
            end
            pending_full <= 1'b0;
         end
         if (aud.sample_valid) begin
            pending      <= aud.sample;
            pending_full <= 1'b1;
            if (pending_full && !frame_start && (overruns != 8'hFF)) begin
               overruns <= overruns + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_audio_out.sv
// tb/tb_i2s_audio_out.sv - directed self-checking bench for i2s_audio_out (DIV=2)
module tb_i2s_audio_out;

   localparam int DIV = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] underruns;
   logic [7:0] overruns;

   int n_checks = 0;
   int n_fail   = 0;
   int e        = 0;

   i2s_audio_out_if #(.WIDTH(16)) aud ();

   i2s_audio_out #(.DIV(DIV), .WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .aud       (aud),
      .enable    (enable),
      .underruns (underruns),
      .overruns  (overruns)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic run_to(input int t);
      while (e < t) begin
         @(posedge clk);
         #1;
         e++;
      end
   endtask

   task automatic strobe(input logic [15:0] v, input int at);
      run_to(at - 1);
      aud.sample       = v;
      aud.sample_valid = 1'b1;
      run_to(at);
      aud.sample_valid = 1'b0;
   endtask

   function automatic logic exp_bit(input logic [15:0] s, input int k);
      int p;
      p = k % 32;
      if (p >= 1 && p <= 16) return s[16-p];
      return 1'b0;
   endfunction

   // Frame f starts on edge 256*f; fall k of the frame sits on edge 256*f + 4*k.
   task automatic check_frame(input int f, input logic [15:0] s, input bit do_strobe, input logic [15:0] v);
      for (int k = 0; k < 64; k++) begin
         run_to(256 * f + 4 * k);
         check("sdata", 16'(aud.sdata), 16'(exp_bit(s, k)));
         check("lrclk", 16'(aud.lrclk), 16'(k >= 32));
         if (do_strobe && k == 0) strobe(v, 256 * f + 2);
      end
   endtask

   initial begin
      aud.sample       = 16'h0000;
      aud.sample_valid = 1'b0;
      reset            = 1'b1;
      enable           = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bclk", 16'(aud.bclk), 16'd0);
      check("rst_lrclk", 16'(aud.lrclk), 16'd0);
      check("rst_sdata", 16'(aud.sdata), 16'd0);
      check("rst_underruns", 16'(underruns), 16'd0);
      check("rst_overruns", 16'(overruns), 16'd0);

      // Idle run: no samples at all.
      reset  = 1'b0;
      enable = 1'b1;
      e      = 0;
      for (int i = 1; i <= 8; i++) begin
         run_to(i);
         check("idle_bclk", 16'(aud.bclk), 16'((i % 4 == 2) || (i % 4 == 3)));
      end
      for (int t = 9; t <= 512; t++) begin
         run_to(t);
         if (t % 4 == 0) check("idle_sdata", 16'(aud.sdata), 16'd0);
         if (t == 127 || t == 128 || t == 255 || t == 256)
            check("idle_lrclk", 16'(aud.lrclk), 16'(t == 128 || t == 255));
         if (t == 255 || t == 256 || t == 511 || t == 512)
            check("idle_underruns", 16'(underruns), (t == 255) ? 16'd0 : (t == 512) ? 16'd2 : 16'd1);
      end
      check("idle_overruns", 16'(overruns), 16'd0);

      // Asynchronous reset mid-frame.
      run_to(514);
      check("pre_rst_bclk", 16'(aud.bclk), 16'd1);
      check("pre_rst_underruns", 16'(underruns), 16'd2);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_bclk", 16'(aud.bclk), 16'd0);
      check("async_rst_underruns", 16'(underruns), 16'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      enable = 1'b1;
      e      = 0;

      // Bit order, repeat-on-underrun, overrun and simultaneous strobe.
      strobe(16'h8001, 10);
      run_to(256);
      check("f1_underruns", 16'(underruns), 16'd0);
      check_frame(1, 16'h8001, 1'b1, 16'h1234);
      run_to(512);
      check("f2_underruns", 16'(underruns), 16'd0);
      check_frame(2, 16'h1234, 1'b0, 16'h0000);
      run_to(768);
      check("f3_underruns", 16'(underruns), 16'd1);
      check_frame(3, 16'h1234, 1'b0, 16'h0000);
      run_to(1024);
      check("f4_underruns", 16'(underruns), 16'd2);
      check("f4_overruns", 16'(overruns), 16'd0);
      strobe(16'h0001, 1030);
      check("ovr_first", 16'(overruns), 16'd0);
      strobe(16'h0002, 1040);
      check("ovr_second", 16'(overruns), 16'd1);
      strobe(16'h0003, 1050);
      check("ovr_third", 16'(overruns), 16'd2);
      run_to(1280);
      check("f5_underruns", 16'(underruns), 16'd2);
      check_frame(5, 16'h0003, 1'b0, 16'h0000);
      strobe(16'hA5C3, 1536);
      check("simul_underruns", 16'(underruns), 16'd3);
      check("simul_overruns", 16'(overruns), 16'd2);
      check_frame(6, 16'h0003, 1'b0, 16'h0000);
      run_to(1792);
      check("f7_underruns", 16'(underruns), 16'd3);
      check_frame(7, 16'hA5C3, 1'b0, 16'h0000);
      check("f7_overruns", 16'(overruns), 16'd2);

      // Saturation of the underrun counter.
      run_to(66303);
      check("sat_254", 16'(underruns), 16'd254);
      run_to(66304);
      check("sat_255", 16'(underruns), 16'd255);
      run_to(67584);
      check("sat_hold", 16'(underruns), 16'd255);

      // Disable mid right slot (bit_cnt 35, p=3 -> A5C3[13]=1).
      run_to(67724);
      check("mid_bclk", 16'(aud.bclk), 16'd0);
      check("mid_lrclk", 16'(aud.lrclk), 16'd1);
      check("mid_sdata", 16'(aud.sdata), 16'd1);
      run_to(67726);
      check("mid_bclk_hi", 16'(aud.bclk), 16'd1);
      enable = 1'b0;
      run_to(67727);
      check("dis_bclk", 16'(aud.bclk), 16'd0);
      check("dis_lrclk", 16'(aud.lrclk), 16'd0);
      check("dis_sdata", 16'(aud.sdata), 16'd0);
      check("dis_underruns", 16'(underruns), 16'd255);
      check("dis_overruns", 16'(overruns), 16'd2);
      strobe(16'h4000, 67730);
      run_to(67740);
      check("dis_hold_bclk", 16'(aud.bclk), 16'd0);
      check("dis_cap_overruns", 16'(overruns), 16'd2);

      // Re-enable: fresh frame from bit_cnt 0.
      enable = 1'b1;
      e      = 0;
      run_to(3);
      check("re_bclk_hi", 16'(aud.bclk), 16'd1);
      check("re_sdata_pre", 16'(aud.sdata), 16'd0);
      run_to(4);
      check("re_bclk_fall", 16'(aud.bclk), 16'd0);
      check("re_lrclk", 16'(aud.lrclk), 16'd0);
      check("re_first_msb", 16'(aud.sdata), 16'd1);
      run_to(128);
      check("re_lrclk_right", 16'(aud.lrclk), 16'd1);
      run_to(256);
      check("re_f1_underruns", 16'(underruns), 16'd255);
      check("re_f1_overruns", 16'(overruns), 16'd2);
      run_to(260);
      check("re_f1_b15", 16'(aud.sdata), 16'd0);
      run_to(264);
      check("re_f1_b14", 16'(aud.sdata), 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
